// File: rtl/matriz_celda_axil_regbank.sv
// AXI4-Lite slave register bank feeding the matriz_celda datapath: byte-strobed writes,
// decoupled AW/W, SLVERR on out-of-range indices. Define MATRIZ_CELDA_RO_STATUS_EN for a read-only status register.
module matriz_celda_axil_regbank #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 4,
  parameter int ADDR_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                           s00_axi_aclk,
  input  logic                           s00_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]          s00_axi_awaddr,
  input  logic [2:0]                     s00_axi_awprot,
  input  logic                           s00_axi_awvalid,
  output logic                           s00_axi_awready,
  input  logic [DATA_WIDTH-1:0]          s00_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s00_axi_wstrb,
  input  logic                           s00_axi_wvalid,
  output logic                           s00_axi_wready,
  output logic [1:0]                     s00_axi_bresp,
  output logic                           s00_axi_bvalid,
  input  logic                           s00_axi_bready,
  input  logic [ADDR_WIDTH-1:0]          s00_axi_araddr,
  input  logic [2:0]                     s00_axi_arprot,
  input  logic                           s00_axi_arvalid,
  output logic                           s00_axi_arready,
  output logic [DATA_WIDTH-1:0]          s00_axi_rdata,
  output logic [1:0]                     s00_axi_rresp,
  output logic                           s00_axi_rvalid,
  input  logic                           s00_axi_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            reg_wr_pulse
`ifdef MATRIZ_CELDA_RO_STATUS_EN
  , input logic [DATA_WIDTH-1:0]         status_in
`endif
);

  localparam int ADDR_LSB = $clog2(DATA_WIDTH / 8);
  localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
  localparam int STRB_W   = DATA_WIDTH / 8;
`ifdef MATRIZ_CELDA_RO_STATUS_EN
  localparam int NUM_RW   = NUM_REGS - 1;
`else
  localparam int NUM_RW   = NUM_REGS;
`endif

  typedef enum logic { W_IDLE, W_RESP } w_state_t;
  typedef enum logic { R_IDLE, R_DATA } r_state_t;

  w_state_t                w_state;
  r_state_t                r_state;
  logic [DATA_WIDTH-1:0]   regs_q [NUM_RW];
  logic                    run_q;
  logic                    aw_have, w_have, ar_have;
  logic [IDX_W-1:0]        aw_idx, ar_idx;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [STRB_W-1:0]       w_strb;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    rd_err;
  logic                    aw_hs, w_hs;
  logic                    unused;

  assign unused = ^{s00_axi_awprot, s00_axi_arprot,
                    s00_axi_awaddr[ADDR_LSB-1:0], s00_axi_araddr[ADDR_LSB-1:0]};

  // Ready re-opens during the B handshake cycle so writes can stream every two cycles.
  assign s00_axi_awready = run_q && !aw_have && (w_state == W_IDLE || s00_axi_bready);
  assign s00_axi_wready  = run_q && !w_have  && (w_state == W_IDLE || s00_axi_bready);
  assign aw_hs = s00_axi_awvalid && s00_axi_awready;
  assign w_hs  = s00_axi_wvalid  && s00_axi_wready;

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      w_state        <= W_IDLE;
      run_q          <= 1'b0;
      aw_have        <= 1'b0;
      w_have         <= 1'b0;
      aw_idx         <= '0;
      w_data         <= '0;
      w_strb         <= '0;
      s00_axi_bvalid <= 1'b0;
      s00_axi_bresp  <= 2'b00;
      reg_wr_pulse   <= '0;
      for (int k = 0; k < NUM_RW; k++) regs_q[k] <= RESET_VALUE;
    end else begin
      run_q        <= 1'b1;
      reg_wr_pulse <= '0;
      case (w_state)
        W_IDLE: begin
          if (aw_have && w_have) begin
            aw_have        <= 1'b0;
            w_have         <= 1'b0;
            w_state        <= W_RESP;
            s00_axi_bvalid <= 1'b1;
            s00_axi_bresp  <= (int'(aw_idx) < NUM_RW) ? 2'b00 : 2'b10;
            for (int k = 0; k < NUM_RW; k++) begin
              if (int'(aw_idx) == k) begin
                reg_wr_pulse[k] <= 1'b1;
                for (int b = 0; b < STRB_W; b++)
                  if (w_strb[b]) regs_q[k][b*8 +: 8] <= w_data[b*8 +: 8];
              end
            end
          end
        end
        W_RESP: begin
          if (s00_axi_bready) begin
            s00_axi_bvalid <= 1'b0;
            w_state        <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
      if (aw_hs) begin
        aw_have <= 1'b1;
        aw_idx  <= s00_axi_awaddr[ADDR_WIDTH-1:ADDR_LSB];
      end
      if (w_hs) begin
        w_have <= 1'b1;
        w_data <= s00_axi_wdata;
        w_strb <= s00_axi_wstrb;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b1;
    for (int k = 0; k < NUM_RW; k++) begin
      if (int'(ar_idx) == k) begin
        rd_data = regs_q[k];
        rd_err  = 1'b0;
      end
    end
`ifdef MATRIZ_CELDA_RO_STATUS_EN
    if (int'(ar_idx) == NUM_REGS - 1) begin
      rd_data = status_in;
      rd_err  = 1'b0;
    end
`endif
  end

  // Address is latched on the AR edge; data is captured one edge later.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_state         <= R_IDLE;
      s00_axi_arready <= 1'b0;
      ar_have         <= 1'b0;
      ar_idx          <= '0;
      s00_axi_rvalid  <= 1'b0;
      s00_axi_rresp   <= 2'b00;
      s00_axi_rdata   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_have) begin
            ar_have        <= 1'b0;
            r_state        <= R_DATA;
            s00_axi_rvalid <= 1'b1;
            s00_axi_rdata  <= rd_data;
            s00_axi_rresp  <= rd_err ? 2'b10 : 2'b00;
          end else if (s00_axi_arvalid && s00_axi_arready) begin
            ar_have         <= 1'b1;
            s00_axi_arready <= 1'b0;
            ar_idx          <= s00_axi_araddr[ADDR_WIDTH-1:ADDR_LSB];
          end else begin
            s00_axi_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (s00_axi_rready) begin
            s00_axi_rvalid  <= 1'b0;
            r_state         <= R_IDLE;
            s00_axi_arready <= 1'b1;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_RW; k++) begin : g_out
    assign reg_out[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[k];
  end
`ifdef MATRIZ_CELDA_RO_STATUS_EN
  assign reg_out[(NUM_REGS-1)*DATA_WIDTH +: DATA_WIDTH] = status_in;
`endif

endmodule

// File: doc/matriz_celda_axil_regbank.md
Name: matriz_celda_axil_regbank

Overview:
Parametrised AXI4-Lite slave register bank, successor to the fixed 4 x 32-bit matriz_celda register slave. It adds configurable register count and data width, byte-strobe writes, decoupled AW/W acceptance, SLVERR on out-of-range access, and per-register write pulses. It exposes the register contents to the matrix cell datapath, and sits behind the PS AXI interconnect (GP port) on the zedboard.

Parameters:
DATA_WIDTH, 32, AXI data width; 32 or 64 only.
NUM_REGS, 4, number of registers; 1..64, need not be a power of 2.
ADDR_WIDTH, 4, AXI address width; must be >= clog2(NUM_REGS) + ADDR_LSB, where ADDR_LSB = clog2(DATA_WIDTH/8).
RESET_VALUE, 0, reset value loaded into every register (DATA_WIDTH bits).

Ports:
s00_axi_aclk  in  1  clock; all logic is on its rising edge
s00_axi_aresetn  in  1  asynchronous active-low reset
s00_axi_awaddr  in  ADDR_WIDTH  write address
s00_axi_awprot  in  3  ignored
s00_axi_awvalid / s00_axi_awready  in/out  1  AW handshake
s00_axi_wdata  in  DATA_WIDTH  write data
s00_axi_wstrb  in  DATA_WIDTH/8  byte enables
s00_axi_wvalid / s00_axi_wready  in/out  1  W handshake
s00_axi_bresp  out  2  OKAY (00) or SLVERR (10)
s00_axi_bvalid / s00_axi_bready  out/in  1  B handshake
s00_axi_araddr  in  ADDR_WIDTH  read address
s00_axi_arprot  in  3  ignored
s00_axi_arvalid / s00_axi_arready  in/out  1  AR handshake
s00_axi_rdata  out  DATA_WIDTH  read data
s00_axi_rresp  out  2  OKAY or SLVERR
s00_axi_rvalid / s00_axi_rready  out/in  1  R handshake
reg_out  out  NUM_REGS*DATA_WIDTH  all registers flattened; register k occupies [k*DATA_WIDTH +: DATA_WIDTH]
reg_wr_pulse  out  NUM_REGS  one-cycle pulse per register on a successful write commit

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - All registers = RESET_VALUE.
  - awready = wready = arready = 0 while asserted; all become 1 on the first clock edge after release.
  - bvalid = rvalid = 0; bresp = rresp = 00; rdata = 0; reg_wr_pulse = 0.
  - Reset mid-transaction aborts it silently; no response is ever issued for it.
- Address decode: index = addr[ADDR_WIDTH-1:ADDR_LSB]; bits [ADDR_LSB-1:0] are ignored. index >= NUM_REGS is out of range.
- Write FSM, states W_IDLE, W_RESP:
  - W_IDLE: awready and wready are driven independently. On an AW handshake, latch the address and drop awready. On a W handshake, latch data and strobe and drop wready. AW and W may arrive in either order or in the same cycle.
  - Commit happens on the edge after both channels are latched: transition to W_RESP, set bvalid = 1, and set bresp.
    - In range: bresp = 00. Update only the byte lanes with wstrb = 1. Pulse reg_wr_pulse[index] for one cycle, coincident with the first bvalid cycle. wstrb = 0 still gives OKAY and a pulse, with no data change.
    - Out of range: bresp = 10. No register change, no pulse.
  - W_RESP: hold bvalid and bresp until bready. On handshake, clear bvalid, go to W_IDLE, and re-raise awready and wready.
  - Minimum write latency: AW+W handshake at edge N -> commit and bvalid at edge N+1. Back-to-back writes every 2 cycles when bready is held at 1.
- Read FSM, states R_IDLE, R_DATA:
  - R_IDLE: arready = 1. On AR handshake at edge N: arready = 0; at edge N+1, rdata = register[index] (or 0 if out of range), rresp = 00/10, rvalid = 1.
  - R_DATA: hold rdata, rresp and rvalid stable until rready, then return to R_IDLE.
- Read and write channels are fully independent. If a write commit and a read capture of the same register occur on the same edge, the read returns the pre-write value.
- reg_out is driven directly from the register flops: new data is visible the cycle after commit.

Optional Feature:
MATRIZ_CELDA_RO_STATUS_EN
- Defined:
  - Adds input port status_in (DATA_WIDTH bits).
  - Register NUM_REGS-1 becomes read-only: reads return status_in as sampled at the AR capture edge.
  - Writes to it get bresp = 10, with no pulse and no change.
  - Its reg_out slice carries status_in.
  - Requires NUM_REGS >= 2.
- Undefined: no status_in port; all registers are read/write.

Test Plan:
- Write 0x1,0x2,0x3,0x4 to 0x0/0x4/0x8/0xC, then read all four -> each read returns the written value with rresp = 00; one reg_wr_pulse per write at bit 0,1,2,3.
- Write 0xAABBCCDD to 0x4 with wstrb = 1111, then 0x11223344 with wstrb = 0101 -> read 0x4 returns 0xAA22CC44; reg_out[63:32] = 0xAA22CC44.
- Present W 3 cycles before AW, then AW alone -> bvalid rises exactly 1 cycle after the AW handshake; holding bready = 0 for 5 cycles keeps bvalid = 1 and awready = wready = 0.
- With NUM_REGS = 3, write and read 0xC -> bresp = 10, rresp = 10, rdata = 0, regs unchanged, no pulse.
- Assert s00_axi_aresetn low while bvalid = 1 after writing 0x5 to 0x8 -> bvalid = 0 immediately; after release, read of 0x8 returns RESET_VALUE.
- MATRIZ_CELDA_RO_STATUS_EN defined, NUM_REGS = 4, status_in = 0xCAFE0001: write 0xC -> bresp = 10; read 0xC -> 0xCAFE0001.
